bus_arbiter: RTL

Two-master arbiter granting the 6502 core and the video scanout reader alternating access to one synchronous single-port RAM. It sits between the CPU core's memory port and the shared 64 KB system RAM, and runs in the main `clock` domain. It uses a fixed three-cycle access sequence and round-robin fairness under contention.

---
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Arbitrates the 6502 core (cpu_*) and the video scanout reader (vid_*)
//   onto one synchronous single-port RAM (mem_*). Each access runs a fixed
//   IDLE -> ADDR -> DATA sequence. Under contention the master that was not
//   granted last wins, so grants strictly alternate.
//
//   Ports
//     clock, reset          system clock, asynchronous active-high reset
//     cpu_req/we/addr/wdata CPU request, held until cpu_ready
//     cpu_rdata, cpu_ready  CPU read data (held) and one-cycle completion pulse
//     vid_req/addr          video read request, held until vid_ready
//     vid_rdata, vid_ready  video read data (held) and one-cycle completion pulse
//     mem_addr/wdata/we     registered RAM address, write data, write strobe
//     mem_rdata             RAM read data, valid one cycle after the address edge
module bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef enum logic {
    MST_CPU,
    MST_VID
  } master_t;

  state_t                  state, state_n;
  // last doubles as "owner of the access in flight" while in ADDR/DATA,
  // because it is updated on every grant.
  master_t                 last, last_n;
  // mem_we is only high during ADDR, so the direction is kept separately
  // for the decision made in DATA.
  logic                    acc_we, acc_we_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_n;
  logic [DATA_WIDTH-1:0]   mem_wdata_n;
  logic                    mem_we_n;
  logic [DATA_WIDTH-1:0]   cpu_rdata_n, vid_rdata_n;
  logic                    cpu_ready_n, vid_ready_n;

  logic cpu_elig, vid_elig;
  logic grant_cpu, grant_vid;

  // A request seen in its own ready cycle is the tail of the access just
  // completed, not a new one.
  assign cpu_elig  = cpu_req & ~cpu_ready;
  assign vid_elig  = vid_req & ~vid_ready;
  assign grant_cpu = cpu_elig & (~vid_elig | (last == MST_VID));
  assign grant_vid = vid_elig & (~cpu_elig | (last == MST_CPU));

  always_comb begin
    state_n     = state;
    last_n      = last;
    acc_we_n    = acc_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_we_n    = 1'b0;
    cpu_rdata_n = cpu_rdata;
    vid_rdata_n = vid_rdata;
    cpu_ready_n = 1'b0;
    vid_ready_n = 1'b0;

    case (state)
      IDLE: begin
        if (grant_cpu) begin
          mem_addr_n  = cpu_addr;
          mem_wdata_n = cpu_wdata;
          mem_we_n    = cpu_we;
          acc_we_n    = cpu_we;
          last_n      = MST_CPU;
          state_n     = ADDR;
        end else if (grant_vid) begin
          mem_addr_n  = vid_addr;
          acc_we_n    = 1'b0;
          last_n      = MST_VID;
          state_n     = ADDR;
        end
      end

      ADDR: begin
        state_n = DATA;
      end

      DATA: begin
        if (last == MST_CPU) begin
          cpu_ready_n = 1'b1;
          if (!acc_we) begin
            cpu_rdata_n = mem_rdata;
          end
        end else begin
          vid_ready_n = 1'b1;
          vid_rdata_n = mem_rdata;
        end
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= MST_VID;
      acc_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      cpu_ready <= 1'b0;
      vid_ready <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      acc_we    <= acc_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
      cpu_rdata <= cpu_rdata_n;
      vid_rdata <= vid_rdata_n;
      cpu_ready <= cpu_ready_n;
      vid_ready <= vid_ready_n;
    end
  end

  a_ready_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(cpu_ready && vid_ready));

  a_we_cpu_addr_only: assert property (@(posedge clock) disable iff (reset)
    mem_we |-> (state == ADDR && last == MST_CPU));

endmodule
